latch_write_arbiter: RTL



---
 rtl/latch_arb_pkg.sv | 32 +++
 rtl/rr_pick.sv | 32 +++
 rtl/latch_write_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/latch_arb_pkg.sv
// Shared types and helpers for latch_write_arbiter: FSM state encoding and the
// round-robin search used by rr_pick.
package latch_arb_pkg;

  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRelease,
    StDone
  } arb_state_e;

  // Index of the first set bit of req at or after ptr, wrapping modulo n.
  // Walks offsets from high to low so the smallest offset is the last assignment.
  function automatic logic [MaxIdxW-1:0] rr_next(input logic [MaxReq-1:0]  req,
                                                 input logic [MaxIdxW-1:0] ptr,
                                                 input int unsigned        n);
    logic [MaxIdxW-1:0] res;
    int                 idx;
    res = '0;
    for (int i = MaxReq - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(n)) idx = idx - int'(n);
      if ((i < int'(n)) && req[idx[MaxIdxW-1:0]]) res = idx[MaxIdxW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot winner among req_i, searching
// upward from ptr_i with wraparound.
module rr_pick
  import latch_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PtrW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             valid_o
);

  logic [MaxReq-1:0]  req_ext;
  logic [MaxIdxW-1:0] ptr_ext;
  logic [MaxIdxW-1:0] idx;

  always_comb begin
    req_ext                = '0;
    req_ext[N_REQ-1:0]     = req_i;
    ptr_ext                = '0;
    ptr_ext[PtrW-1:0]      = ptr_i;
    idx                    = rr_next(req_ext, ptr_ext, N_REQ);
    valid_o                = |req_i;
    winner_o               = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      winner_o[i] = valid_o && (idx == MaxIdxW'(i));
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter and setup/strobe/hold sequencer for a shared D-type
// storage element. Define LATCH_ARB_READBACK_EN to add Q readback and the err pulse.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       D,
  output logic                   E,
  output logic                   busy
`ifdef LATCH_ARB_READBACK_EN
  ,
  input  logic [WIDTH-1:0]       Q,
  output logic                   err
`endif
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              e_q, e_d;
  logic              busy_q, busy_d;
`ifdef LATCH_ARB_READBACK_EN
  logic              err_q, err_d;
`endif

  logic [N_REQ-1:0]  pick_oh;
  logic              pick_valid;
  logic [PtrW-1:0]   pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_oh),
    .valid_o  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_oh[i]) pick_idx = PtrW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    d_d        = d_q;
    e_d        = e_q;
`ifdef LATCH_ARB_READBACK_EN
    err_d      = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          gnt_d   = pick_oh;
          d_d     = din[pick_idx*WIDTH +: WIDTH];
          state_d = StSetup;
        end
      end
      StSetup: begin
        e_d        = 1'b1;
        hold_cnt_d = '0;
        state_d    = StStrobe;
      end
      StStrobe: begin
        if (hold_cnt_q == HoldLast) begin
          e_d        = 1'b0;
          hold_cnt_d = '0;
          state_d    = StRelease;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        // D is still held here, so the cell output should already reflect it.
        gnt_d           = '0;
        done_d          = '0;
        done_d[win_q]   = 1'b1;
`ifdef LATCH_ARB_READBACK_EN
        err_d           = (Q != d_q);
`endif
        state_d         = StDone;
      end
      StDone: begin
        ptr_d   = (win_q == PtrLast) ? '0 : win_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      win_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      d_q        <= '0;
      e_q        <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LATCH_ARB_READBACK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      d_q        <= d_d;
      e_q        <= e_d;
      busy_q     <= busy_d;
`ifdef LATCH_ARB_READBACK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign D    = d_q;
  assign E    = e_q;
  assign busy = busy_q;
`ifdef LATCH_ARB_READBACK_EN
  assign err  = err_q;
`endif

endmodule
